// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver: synchronises the serial line, decides each bit by a
// 2-of-3 majority around mid-bit and reports good frames or stop-bit framing errors.
module uart_rx_sampler #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_pin_i,
    input  logic [15:0]          baud_div_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic [2:0]           fsm_state
);

    localparam int SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [SW-1:0] TICK_A    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] TICK_B    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] TICK_C    = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] TICK_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line;
    logic                   line_prev;
    logic                   fell;

    logic [15:0]            div_cnt;
    logic [15:0]            div_lim;
    logic [15:0]            div_reload;
    logic                   tick;

    logic [SW-1:0]          samp_cnt;
    logic                   samp_a;
    logic                   samp_b;
    logic                   voted;
    logic                   decide;
    logic                   wrap;

    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;

    logic [2:0]             state;
    logic [2:0]             state_n;
    logic                   start_frame;
    logic                   shift_en;
    logic                   load_data;
    logic                   set_ferr;

    // Synchroniser resets to the idle (high) level so reset release never fakes a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '1;
            line_prev <= 1'b1;
        end else begin
            sync_q[0] <= rx_pin_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            line_prev <= line;
        end
    end

    assign line = sync_q[SYNC_STAGES-1];
    assign fell = line_prev & ~line;

    // A divisor of zero behaves as one; the limit is only sampled at reload.
    assign div_reload = (baud_div_i == 16'd0) ? 16'd0 : baud_div_i - 16'd1;
    assign tick       = (state != ST_IDLE) && (div_cnt == div_lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 16'd0;
            div_lim <= 16'd0;
        end else if (start_frame) begin
            div_cnt <= 16'd0;
            div_lim <= div_reload;
        end else if (state != ST_IDLE) begin
            if (tick) begin
                div_cnt <= 16'd0;
                div_lim <= div_reload;
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

    assign decide = tick && (samp_cnt == TICK_C);
    assign wrap   = tick && (samp_cnt == TICK_LAST);
    // Third vote is the live line value at the decision tick.
    assign voted  = (samp_a & samp_b) | (samp_a & line) | (samp_b & line);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt <= '0;
            samp_a   <= 1'b0;
            samp_b   <= 1'b0;
        end else if (start_frame) begin
            samp_cnt <= '0;
        end else if (tick) begin
            samp_cnt <= (samp_cnt == TICK_LAST) ? '0 : samp_cnt + SW'(1);
            if (samp_cnt == TICK_A) samp_a <= line;
            if (samp_cnt == TICK_B) samp_b <= line;
        end
    end

    always_comb begin
        state_n     = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        load_data   = 1'b0;
        set_ferr    = 1'b0;
        case (state)
            ST_IDLE: begin
                state_n = ST_IDLE;
            end
            ST_START: begin
                if (decide && voted) begin
                    state_n = ST_IDLE;
                end else if (wrap) begin
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (decide) begin
                    shift_en = 1'b1;
                end
                if (wrap && (bit_cnt == BITS_LAST)) begin
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    if (voted) begin
                        load_data = 1'b1;
                        state_n   = ST_IDLE;
                    end else begin
                        set_ferr  = 1'b1;
                        state_n   = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (line) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        // Any path landing in IDLE also honours a falling edge seen in the same clock.
        if ((state_n == ST_IDLE) && fell) begin
            state_n     = ST_START;
            start_frame = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            if ((state == ST_START) && wrap) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (shift_en) begin
                shreg <= {voted, shreg[DATA_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_o   <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            valid_o     <= load_data;
            frame_err_o <= set_ferr;
            if (load_data) begin
                rx_data_o <= shreg;
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: table of directed frames, hand-built corner sequences
// and random frames checked against a frame-level model with an expected-data queue.
module tb_uart_rx_sampler;

    localparam logic [2:0] IDLE_CODE = 3'd0;

    typedef struct {
        logic [7:0]  data;
        bit          stop_ok;
        logic [15:0] div;
        int          hold;
        int          gap;
        int          exp_valid;
        int          exp_ferr;
        logic [7:0]  exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_pin = 1'b1;
    logic [15:0] baud_div = 16'd4;
    logic [7:0]  rx_data;
    logic        valid;
    logic        ferr;
    logic [2:0]  fsm_state;

    int          n_checks = 0;
    int          n_fail = 0;
    int          valid_cnt = 0;
    int          ferr_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  model_data = 8'h00;
    logic [7:0]  held = 8'h00;
    vec_t        vecs[7];

    uart_rx_sampler #(
        .DATA_BITS(8),
        .OVERSAMPLE(16),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_pin_i(rx_pin),
        .baud_div_i(baud_div),
        .rx_data_o(rx_data),
        .valid_o(valid),
        .frame_err_o(ferr),
        .fsm_state(fsm_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest expected byte.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 8'h00;
        end else begin
            if (valid || ferr) check("pulse_exclusive", {31'd0, valid & ferr}, 32'd0);
            if (ferr) ferr_cnt++;
            if (valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got data 0x%0h, expected no pulse", rx_data);
                end else begin
                    check("valid_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
                held = rx_data;
            end else begin
                check("rx_data_hold", {24'd0, rx_data}, {24'd0, held});
            end
        end
    end

    // Driver tasks
    task automatic hold_line(input logic v, input int n);
        rx_pin = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int hold);
        int bc;
        bc = 16 * ((baud_div == 16'd0) ? 1 : int'(baud_div));
        hold_line(1'b0, bc);
        for (int i = 0; i < 8; i++) hold_line(d[i], bc);
        hold_line(stop_ok, bc);
        if (!stop_ok && hold > 0) hold_line(1'b0, hold);
        rx_pin = 1'b1;
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input bit ok, input int hold,
                             input int gap, input int exp_v, input int exp_f,
                             input logic [7:0] exp_d);
        int v0;
        int f0;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        if (exp_v != 0) exp_q.push_back(exp_d);
        send_frame(d, ok, hold);
        hold_line(1'b1, gap);
        check({name, "_valid_cnt"}, valid_cnt - v0, exp_v);
        check({name, "_ferr_cnt"}, ferr_cnt - f0, exp_f);
        check({name, "_rx_data"}, {24'd0, rx_data}, {24'd0, exp_d});
        model_data = exp_d;
    endtask

    initial begin
        int v0;
        int f0;
        int bc;
        logic [7:0] d;
        bit ok;
        int hold;

        vecs[0] = '{8'hA5, 1'b1, 16'd4, 0,   8, 1, 0, 8'hA5};
        vecs[1] = '{8'h81, 1'b0, 16'd4, 200, 8, 0, 1, 8'hA5};
        vecs[2] = '{8'h42, 1'b1, 16'd4, 0,   8, 1, 0, 8'h42};
        vecs[3] = '{8'h6E, 1'b1, 16'd0, 0,   8, 1, 0, 8'h6E};
        vecs[4] = '{8'hC3, 1'b1, 16'd1, 0,   8, 1, 0, 8'hC3};
        vecs[5] = '{8'h17, 1'b0, 16'd2, 0,   8, 0, 1, 8'hC3};
        vecs[6] = '{8'h17, 1'b1, 16'd3, 0,   8, 1, 0, 8'h17};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_ferr", {31'd0, ferr}, 32'd0);
        check("reset_state", {29'd0, fsm_state}, {29'd0, IDLE_CODE});
        rst_n = 1'b1;
        hold_line(1'b1, 10);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            baud_div = vecs[i].div;
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop_ok, vecs[i].hold,
                      vecs[i].gap, vecs[i].exp_valid, vecs[i].exp_ferr, vecs[i].exp_data);
        end

        // Short low glitch is rejected, then a real frame follows
        baud_div = 16'd4;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        hold_line(1'b0, 12);
        hold_line(1'b1, 100);
        check("glitch_valid_cnt", valid_cnt - v0, 0);
        check("glitch_ferr_cnt", ferr_cnt - f0, 0);
        check("glitch_state", {29'd0, fsm_state}, {29'd0, IDLE_CODE});
        run_frame("after_glitch", 8'h3C, 1'b1, 0, 8, 1, 0, 8'h3C);

        // Back-to-back frames with a single stop bit between them
        v0 = valid_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        hold_line(1'b1, 8);
        check("b2b_valid_cnt", valid_cnt - v0, 2);
        check("b2b_rx_data", {24'd0, rx_data}, 32'hFF);
        model_data = 8'hFF;

        // Reset during data bit 3 aborts the frame silently
        baud_div = 16'd4;
        bc = 64;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        d = 8'h5A;
        hold_line(1'b0, bc);
        for (int i = 0; i < 3; i++) hold_line(d[i], bc);
        hold_line(d[3], bc / 2);
        rst_n = 1'b0;
        #1;
        check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
        check("midreset_valid", {31'd0, valid}, 32'd0);
        check("midreset_ferr", {31'd0, ferr}, 32'd0);
        check("midreset_state", {29'd0, fsm_state}, {29'd0, IDLE_CODE});
        rx_pin = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        hold_line(1'b1, 200);
        check("midreset_valid_cnt", valid_cnt - v0, 0);
        check("midreset_ferr_cnt", ferr_cnt - f0, 0);
        model_data = 8'h00;
        run_frame("after_reset", 8'h99, 1'b1, 0, 8, 1, 0, 8'h99);

        // Random frames against the frame-level model
        for (int i = 0; i < 12; i++) begin
            d        = 8'($urandom_range(0, 255));
            baud_div = 16'($urandom_range(0, 3));
            ok       = ($urandom_range(0, 3) != 0);
            hold     = ok ? 0 : int'($urandom_range(0, 100));
            run_frame($sformatf("rand%0d", i), d, ok, hold, int'($urandom_range(2, 20)),
                      ok ? 1 : 0, ok ? 0 : 1, ok ? d : model_data);
        end

        hold_line(1'b1, 20);
        check("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
